// File: rtl/decoder_3_to_8_if.sv
// rtl/decoder_3_to_8_if.sv - select/decode bundle between a requester and the 3-to-8 decoder
//
// Signals:
//   A        [2:0]  binary select, bit 2 = MSB          (master -> slave)
//   En              decode enable, active-high          (master -> slave)
//   Y        [7:0]  registered one-hot decode result    (slave -> master)
//   y_valid         registered copy of En               (slave -> master)
//   y_index  [2:0]  registered copy of A, 0 if disabled (slave -> master)
interface decoder_3_to_8_if;
  logic [2:0] A;
  logic       En;
  logic [7:0] Y;
  logic       y_valid;
  logic [2:0] y_index;

  modport master (
    output A,
    output En,
    input  Y,
    input  y_valid,
    input  y_index
  );

  modport slave (
    input  A,
    input  En,
    output Y,
    output y_valid,
    output y_index
  );
endinterface

// File: rtl/decoder_3_to_8.sv
// rtl/decoder_3_to_8.sv - registered 3-to-8 line decoder with enable
//
// Purpose: turns a 3-bit select into a one-hot 8-bit chip-select word,
// registered so downstream select lines see clean, glitch-free timing.
// One decode per clock, one clock of latency, no input-to-output
// combinational path.
//
// Parameters:
//   OUT_ACTIVE_LOW  0: selected line is 1, others 0
//                   1: selected line is 0, others 1 (also in reset/disabled)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   decoder_3_to_8_if.slave (A, En in; Y, y_valid, y_index out)
module decoder_3_to_8 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  decoder_3_to_8_if.slave   bus
);

  // XOR mask that turns the active-high word into the configured polarity;
  // it is also exactly the "no line selected" word.
  localparam logic [7:0] OFF_WORD = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] hot;

  always_comb begin
    hot = 8'h00;
    if (bus.En) begin
      hot[bus.A] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.Y       <= OFF_WORD;
      bus.y_valid <= 1'b0;
      bus.y_index <= 3'd0;
    end else begin
      bus.Y       <= hot ^ OFF_WORD;
      bus.y_valid <= bus.En;
      bus.y_index <= bus.En ? bus.A : 3'd0;
    end
  end

endmodule

// File: tb/tb_decoder_3_to_8.sv
// tb/tb_decoder_3_to_8.sv - scoreboard bench for both polarities of decoder_3_to_8
module tb_decoder_3_to_8;

  typedef struct packed {
    logic [7:0] y;
    logic       v;
    logic [2:0] idx;
  } exp_t;

  logic clk;
  logic rst;

  decoder_3_to_8_if ifh ();
  decoder_3_to_8_if ifl ();

  decoder_3_to_8 #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (.clk(clk), .rst(rst), .bus(ifh));
  decoder_3_to_8 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (.clk(clk), .rst(rst), .bus(ifl));

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: selected line number a becomes bit weight 2**a; reset or
  // disable means nothing selected.
  function automatic exp_t model(input bit r, input int a, input bit en);
    exp_t e;
    if (r || !en) begin
      e.y   = 8'h00;
      e.v   = 1'b0;
      e.idx = 3'd0;
    end else begin
      e.y   = 8'(2 ** a);
      e.v   = 1'b1;
      e.idx = 3'(a);
    end
    return e;
  endfunction

  task automatic set_inputs(input int a, input bit en);
    ifh.A  = 3'(a);
    ifh.En = en;
    ifl.A  = 3'(a);
    ifl.En = en;
  endtask

  // Present inputs away from the edge, then record what the edge must produce.
  task automatic drive(input int a, input bit en);
    @(negedge clk);
    set_inputs(a, en);
    @(posedge clk);
    sb.push_back(model(rst, a, en));
  endtask

  // Monitor: one expected entry per captured edge, compared mid-cycle.
  initial begin
    exp_t       e;
    logic [7:0] ylo;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        ylo = ~e.y;
        check("y_hi",     ifh.Y,       e.y);
        check("valid_hi", ifh.y_valid, e.v);
        check("index_hi", ifh.y_index, e.idx);
        check("ones_hi",  $countones(ifh.Y), e.v ? 1 : 0);
        check("y_lo",     ifl.Y,       ylo);
        check("valid_lo", ifl.y_valid, e.v);
        check("index_lo", ifl.y_index, e.idx);
      end
    end
  end

  initial begin
    int a;
    bit en;
    rst = 1'b1;
    set_inputs(3, 1'b1);

    // Asynchronous reset values before any clock edge.
    #1;
    check("rst_async_y_hi", ifh.Y, 8'h00);
    check("rst_async_y_lo", ifl.Y, 8'hFF);
    check("rst_async_valid", ifh.y_valid, 1'b0);

    // Reset held with En=1, A=3 and the clock running.
    repeat (3) drive(3, 1'b1);

    @(negedge clk);
    rst = 1'b0;

    // Disabled decode ignores A.
    drive(0, 1'b0);
    drive(5, 1'b0);

    // Full sweep.
    for (int i = 0; i < 8; i++) drive(i, 1'b1);

    // Enable toggle with A fixed.
    drive(6, 1'b1);
    drive(6, 1'b0);
    drive(6, 1'b1);

    // Asynchronous reset in the middle of a sweep at A=4.
    for (int i = 0; i <= 4; i++) drive(i, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_y_hi",  ifh.Y,       8'h00);
    check("mid_rst_valid", ifh.y_valid, 1'b0);
    check("mid_rst_index", ifh.y_index, 3'd0);
    check("mid_rst_y_lo",  ifl.Y,       8'hFF);
    #1;
    rst = 1'b0;
    set_inputs(7, 1'b1);
    @(posedge clk);
    sb.push_back(model(1'b0, 7, 1'b1));

    // Randomised back-to-back traffic, mostly enabled.
    for (int i = 0; i < 200; i++) begin
      a  = int'($urandom_range(0, 7));
      en = ($urandom_range(0, 3) != 0);
      drive(a, en);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_3_to_8.md
Name: decoder_3_to_8

Overview:
- Registered 3-to-8 line decoder with enable.
- Converts a 3-bit binary select into a one-hot 8-bit word; the output is forced all-inactive when disabled.
- Used as an address/chip-select decoder feeding downstream select lines; output is registered for clean timing.

Parameters:
- OUT_ACTIVE_LOW, 0, 0 = selected line driven 1, others 0; 1 = selected line driven 0, others 1 (bitwise inverse of active-high result).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- A  input  3  binary select, bit 2 = MSB
- En  input  1  decode enable, active-high
- Y  output  8  registered one-hot decode result, Y[i] corresponds to A == i
- y_valid  output  1  registered copy of En: Y holds a live decode
- y_index  output  3  registered copy of A captured with the current Y (0 when disabled)

Behaviour:
- Reset (rst=1, asynchronous, no clock needed):
  - Y = 8'h00 (8'hFF if OUT_ACTIVE_LOW=1)
  - y_valid = 0
  - y_index = 0
  - Held while rst=1.
- Reset release is synchronous to the next rising clk; the first decode is captured on the first rising edge with rst=0.
- Each rising clk with rst=0:
  - En=1: active-high Y <= 8'b1 << A (exactly one bit set); y_valid <= 1; y_index <= A.
  - En=0: active-high Y <= 8'h00 regardless of A; y_valid <= 0; y_index <= 0.
- OUT_ACTIVE_LOW=1: Y is the bitwise inverse of the active-high result in every case, including reset and disabled.
- Latency:
  - Exactly 1 clock from A/En sampled to Y/y_valid/y_index.
  - No combinational path from inputs to outputs.
- Mapping (active-high): A=0->8'h01, 1->8'h02, 2->8'h04, 3->8'h08, 4->8'h10, 5->8'h20, 6->8'h40, 7->8'h80.
- Invariants:
  - y_valid=1 implies Y has exactly one active bit, at position y_index.
  - y_valid=0 implies no active bit.
- Simultaneous change of A and En in the same cycle: both are sampled together and the result reflects the new values after one clock.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronously), independent of clk and of A/En.
- A or En containing X/Z is not supported; behaviour is undefined and the bench must not drive it.
- No internal state other than the output registers; back-to-back changes every cycle are fully supported (throughput 1 decode/clock).

Test Plan:
- Reset: rst=1 with En=1, A=3'b011, clock running -> Y=8'h00, y_valid=0, y_index=0 for every cycle rst is held.
- Disabled: rst=0, En=0, A=3'b000 then A=3'b101, one clock each -> Y=8'h00 and y_valid=0 after each edge.
- Full sweep: En=1, A stepped 0..7, one per clock -> one cycle later Y=8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80 in order; y_valid=1; y_index equals the applied A; exactly one bit set each time.
- Enable toggle with A fixed: A=3'b110, En 1->0->1 on consecutive clocks -> Y=8'h40, then 8'h00, then 8'h40, each one cycle after the input change.
- Async reset mid-sweep: during the sweep at A=3'b100, assert rst between clock edges -> Y drops to 8'h00 and y_valid to 0 before the next edge; after release, the first edge with En=1, A=3'b111 gives Y=8'h80.
- Active-low build (OUT_ACTIVE_LOW=1):
  - Reset -> Y=8'hFF.
  - En=1, A=3'b010 -> Y=8'hFB.
  - En=0 -> Y=8'hFF.
